// File: rtl/ship_gun.sv
// ship_gun: player ship controller with a pool of N independent bullets.
// Ship motion, fire edge/auto-fire with cooldown, and bullet retirement on top edge or hit.
module ship_gun #(
    parameter int N_BULLETS = 4,
    parameter int H_SIZE    = 16,
    parameter int B_SIZE    = 4,
    parameter int IX        = 320,
    parameter int IY        = 400,
    parameter int D_WIDTH   = 640,
    parameter int D_HEIGHT  = 480,
    parameter int P_SPEED   = 2,
    parameter int B_SPEED   = 4,
    parameter int COOLDOWN  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_ani_stb,
    input  logic                    i_animate,
    input  logic                    i_paused,
    input  logic [7:0]              i_sw,
    input  logic                    i_auto,
    input  logic [N_BULLETS-1:0]    i_hit,
    output logic [11:0]             o_x1,
    output logic [11:0]             o_x2,
    output logic [11:0]             o_y1,
    output logic [11:0]             o_y2,
    output logic [12*N_BULLETS-1:0] o_bx1,
    output logic [12*N_BULLETS-1:0] o_bx2,
    output logic [12*N_BULLETS-1:0] o_by1,
    output logic [12*N_BULLETS-1:0] o_by2,
    output logic [N_BULLETS-1:0]    o_active,
    output logic                    o_fire,
    output logic [4:0]              o_free_cnt
);
    localparam int CW = $clog2(COOLDOWN + 2);
    localparam logic signed [12:0] X_MIN = 13'(H_SIZE);
    localparam logic signed [12:0] X_MAX = 13'(D_WIDTH - H_SIZE);
    localparam logic signed [12:0] Y_MAX = 13'(D_HEIGHT - H_SIZE);

    logic [11:0]          x, y;
    logic [11:0]          bx [N_BULLETS];
    logic [11:0]          by [N_BULLETS];
    logic [CW-1:0]        cooldown;
    logic                 fire_prev;
    logic                 tick, req, spawn;
    logic [4:0]           tgt;
    logic signed [12:0]   dx, dy, nx, ny;
    logic                 unused;

    assign unused = ^{i_sw[5], i_sw[3:2]};

    always_comb begin
        tick = i_animate & i_ani_stb & ~i_paused;
        req = tick & i_sw[4] & (~fire_prev | i_auto);
        spawn = req & (cooldown == '0) & ~&o_active;
        tgt = '0;
        for (int k = N_BULLETS - 1; k >= 0; k--)
            tgt = !o_active[k] ? 5'(k) : tgt;
        dx = (i_sw[0] ? 13'(P_SPEED) : 13'sd0) - (i_sw[7] ? 13'(P_SPEED) : 13'sd0);
        dy = (i_sw[1] ? 13'(P_SPEED) : 13'sd0) - (i_sw[6] ? 13'(P_SPEED) : 13'sd0);
        nx = $signed({1'b0, x}) + dx;
        ny = $signed({1'b0, y}) + dy;
        o_free_cnt = '0;
        for (int k = 0; k < N_BULLETS; k++)
            o_free_cnt = o_free_cnt + 5'(!o_active[k]);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            x         <= 12'(IX);
            y         <= 12'(IY);
            o_active  <= '0;
            cooldown  <= '0;
            fire_prev <= 1'b1;
            o_fire    <= 1'b0;
            for (int k = 0; k < N_BULLETS; k++) begin
                bx[k] <= '0;
                by[k] <= '0;
            end
        end else begin
            o_fire   <= spawn;
            cooldown <= spawn ? CW'(COOLDOWN) : (tick && cooldown != '0) ? cooldown - CW'(1) : cooldown;
            if (tick) begin
                fire_prev <= i_sw[4];
                x <= nx < X_MIN ? 12'(X_MIN) : nx > X_MAX ? 12'(X_MAX) : 12'(nx);
                y <= ny < X_MIN ? 12'(X_MIN) : ny > Y_MAX ? 12'(Y_MAX) : 12'(ny);
            end
            // target slot is inactive, so a hit on it cannot override the spawn
            for (int k = 0; k < N_BULLETS; k++) begin
                if (spawn && tgt == 5'(k)) begin
                    o_active[k] <= 1'b1;
                    bx[k]       <= x;
                    by[k]       <= y - 12'(H_SIZE);
                end else if (o_active[k] && i_hit[k]) begin
                    o_active[k] <= 1'b0;
                end else if (tick && o_active[k]) begin
                    if (by[k] < 12'(B_SIZE + B_SPEED))
                        o_active[k] <= 1'b0;
                    else
                        by[k] <= by[k] - 12'(B_SPEED);
                end
            end
        end
    end

    assign o_x1 = x - 12'(H_SIZE);
    assign o_x2 = x + 12'(H_SIZE);
    assign o_y1 = y - 12'(H_SIZE);
    assign o_y2 = y + 12'(H_SIZE);

    for (genvar k = 0; k < N_BULLETS; k++) begin : g_edges
        assign o_bx1[12*k +: 12] = bx[k] - 12'(B_SIZE);
        assign o_bx2[12*k +: 12] = bx[k] + 12'(B_SIZE);
        assign o_by1[12*k +: 12] = by[k] - 12'(B_SIZE);
        assign o_by2[12*k +: 12] = by[k] + 12'(B_SIZE);
    end
endmodule
